// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender with prefix fusion.
// Raw immediates from decode are extended according to mode and handed to
// the operand mux over valid/ready. A PREFIX op parks its immediate until the
// next op, which may fuse it into one wide constant. The output side is a
// 2-entry buffer (output register plus skid) so a stalled consumer never
// causes an accepted immediate to be lost.
`timescale 1ns/1ps

module imm_ext_pipe #(
    parameter int N       = 16,
    parameter int M       = 32,
    parameter int SHIFT_B = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] imm_in,
    input  logic [2:0]   mode,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] imm_out,
    output logic         prefix_pending,
    output logic         prefix_err
);

    // A fused constant must fit in the output word.
    generate
        if (M < 2 * N) begin : g_bad_width
            $error("imm_ext_pipe: M must be at least 2*N");
        end
    endgenerate

    localparam logic [2:0] MODE_ZERO   = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_UPPER  = 3'd2;
    localparam logic [2:0] MODE_BRANCH = 3'd3;
    localparam logic [2:0] MODE_PREFIX = 3'd4;

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   prefix_q;
    logic           prefix_load;
    logic           err_next;
    logic           out_valid_q;
    logic [M-1:0]   imm_q;
    logic           skid_valid;
    logic [M-1:0]   skid_data;
    logic [M-1:0]   normal_res;
    logic [M-1:0]   result;
    logic           produce;
    logic           accept;
    logic           drain;

    // The skid entry is the only thing that can block a new immediate.
    assign in_ready       = !skid_valid;
    assign accept         = in_valid && in_ready && !flush;
    assign drain          = out_valid_q && out_ready;
    assign out_valid      = out_valid_q;
    assign imm_out        = imm_q;
    assign prefix_pending = (state == HELD);

    // Single-immediate extension; reserved modes behave like SIGN.
    always_comb begin
        normal_res = M'($signed(imm_in));
        case (mode)
            MODE_ZERO:   normal_res = M'(imm_in);
            MODE_UPPER:  normal_res = {imm_in, {(M - N){1'b0}}};
            MODE_BRANCH: normal_res = M'($signed(imm_in)) << SHIFT_B;
            default:     normal_res = M'($signed(imm_in));
        endcase
    end

    // Prefix FSM: decides whether this op stores, fuses, or drops a prefix.
    always_comb begin
        state_next  = state;
        result      = normal_res;
        produce     = 1'b0;
        prefix_load = 1'b0;
        err_next    = 1'b0;
        if (accept) begin
            if (mode == MODE_PREFIX) begin
                prefix_load = 1'b1;
                state_next  = HELD;
                err_next    = (state == HELD);
            end else begin
                produce    = 1'b1;
                state_next = IDLE;
                if (state == HELD) begin
                    if (mode == MODE_ZERO) begin
                        result = M'({prefix_q, imm_in});
                    end else if (mode == MODE_SIGN) begin
                        result = M'($signed({prefix_q, imm_in}));
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
        end
    end

    // Prefix state, stored prefix half and the one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prefix_q   <= '0;
            prefix_err <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            prefix_err <= 1'b0;
        end else begin
            state      <= state_next;
            prefix_err <= err_next;
            if (prefix_load) begin
                prefix_q <= imm_in;
            end
        end
    end

    // Output register plus skid: FIFO order, skid refills the output on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                imm_q      <= skid_data;
                skid_valid <= 1'b0;
            end else if (produce) begin
                imm_q <= result;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (produce) begin
            if (!out_valid_q) begin
                imm_q       <= result;
                out_valid_q <= 1'b1;
            end else begin
                skid_data  <= result;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule
